// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register responder.
package axi_lite_pkg;

   localparam int AXI_DATA_W = 32;
   localparam int AXI_STRB_W = AXI_DATA_W / 8;

   // Only the two response codes this responder can produce.
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_EXEC,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_EXEC,
      R_WAIT,
      R_RESP
   } rd_state_t;

   // Response code for an access that did or did not hit the window.
   function automatic resp_t resp_for(input logic hit);
      return hit ? OKAY : SLVERR;
   endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder that turns bus transactions into single-cycle
// register-file strobes. One write and one read may be outstanding; a
// 1-bit arbiter keeps the two strobes mutually exclusive.
module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = AXI_DATA_W,
   parameter int                    WIN_BITS   = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   // write address channel
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [2:0]              awprot,
   input  logic                    awvalid,
   output logic                    awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   // write response channel
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   // read address channel
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [2:0]              arprot,
   input  logic                    arvalid,
   output logic                    arready,
   // read data channel
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   // register-file strobe interface
   output logic                    reg_wr_en,
   output logic [WIN_BITS-3:0]     reg_wr_addr,
   output logic [DATA_WIDTH-1:0]   reg_wr_data,
   output logic [DATA_WIDTH/8-1:0] reg_wr_strb,
   output logic                    reg_rd_en,
   output logic [WIN_BITS-3:0]     reg_rd_addr,
   input  logic [DATA_WIDTH-1:0]   reg_rd_data
);

   localparam int WORD_W = WIN_BITS - 2;
   localparam int STRB_W = AXI_STRB_W;

   // Upper address bits must match the base for the access to land here.
   function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:WIN_BITS] == BASE_ADDR[ADDR_WIDTH-1:WIN_BITS];
   endfunction

   // Channel buffers: the window decode is done once, at capture time.
   logic                  aw_full, w_full, ar_full;
   logic                  aw_hit_q, ar_hit_q;
   logic [WORD_W-1:0]     aw_word_q, ar_word_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   resp_t     bresp_q, rresp_q;

   // Set when the last contended grant went to the write side.
   logic prio_rd;

   logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic wr_req, rd_req, wr_grant, rd_grant;

   // Protection bits and byte-offset address bits carry no meaning here.
   logic unused;
   assign unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid  & wready;
   assign ar_hs = arvalid & arready;
   assign b_hs  = bvalid  & bready;
   assign r_hs  = rvalid  & rready;

   // Arbiter: an uncontended request always wins; on contention the side
   // that lost the previous contention goes first.
   assign wr_req   = (wr_state == W_IDLE) & aw_full & w_full;
   assign rd_req   = (rd_state == R_IDLE) & ar_full;
   assign wr_grant = wr_req & (~rd_req | ~prio_rd);
   assign rd_grant = rd_req & (~wr_req |  prio_rd);

   assign reg_wr_addr = aw_word_q;
   assign reg_wr_data = wdata_q;
   assign reg_wr_strb = wstrb_q;
   assign reg_rd_addr = ar_word_q;
   assign bresp       = bresp_q;
   assign rresp       = rresp_q;

   // Capture AW/W/AR independently; each ready stays low from its handshake
   // until the owning transaction's response handshake empties the buffer.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         ar_full   <= 1'b0;
         awready   <= 1'b0;
         wready    <= 1'b0;
         arready   <= 1'b0;
         aw_hit_q  <= 1'b0;
         ar_hit_q  <= 1'b0;
         aw_word_q <= '0;
         ar_word_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         if (aw_hs) begin
            aw_full   <= 1'b1;
            awready   <= 1'b0;
            aw_hit_q  <= in_window(awaddr);
            aw_word_q <= awaddr[WIN_BITS-1:2];
         end else if (b_hs) begin
            aw_full <= 1'b0;
            awready <= 1'b1;
         end else begin
            awready <= ~aw_full;
         end

         if (w_hs) begin
            w_full  <= 1'b1;
            wready  <= 1'b0;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end else if (b_hs) begin
            w_full <= 1'b0;
            wready <= 1'b1;
         end else begin
            wready <= ~w_full;
         end

         if (ar_hs) begin
            ar_full   <= 1'b1;
            arready   <= 1'b0;
            ar_hit_q  <= in_window(araddr);
            ar_word_q <= araddr[WIN_BITS-1:2];
         end else if (r_hs) begin
            ar_full <= 1'b0;
            arready <= 1'b1;
         end else begin
            arready <= ~ar_full;
         end
      end
   end

   // State registers, arbitration flag and registered response fields.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state <= W_IDLE;
         rd_state <= R_IDLE;
         prio_rd  <= 1'b0;
         bresp_q  <= OKAY;
         rresp_q  <= OKAY;
         rdata    <= '0;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
         if (wr_req & rd_req) prio_rd <= wr_grant;
         if (wr_state == W_EXEC) bresp_q <= resp_for(aw_hit_q);
         // Register data is valid in the cycle after the read strobe.
         if (rd_state == R_WAIT) begin
            rresp_q <= resp_for(ar_hit_q);
            rdata   <= ar_hit_q ? reg_rd_data : '0;
         end
      end
   end

   // Write FSM next state and outputs.
   // NOTE: every output of a combinational block gets a default first, so
   // no path through the case leaves a value unassigned and infers a latch.
   always_comb begin
      wr_next   = wr_state;
      reg_wr_en = 1'b0;
      bvalid    = 1'b0;
      unique case (wr_state)
         W_IDLE: if (wr_grant) wr_next = W_EXEC;
         W_EXEC: begin
            reg_wr_en = aw_hit_q;
            wr_next   = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // Read FSM next state and outputs.
   always_comb begin
      rd_next   = rd_state;
      reg_rd_en = 1'b0;
      rvalid    = 1'b0;
      unique case (rd_state)
         R_IDLE: if (rd_grant) rd_next = R_EXEC;
         R_EXEC: begin
            reg_rd_en = ar_hit_q;
            rd_next   = R_WAIT;
         end
         R_WAIT: rd_next = R_RESP;
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: a small register model answers the
// strobe interface and a negedge monitor timestamps strobes and responses.
module tb_axi_lite_reg_slave;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, arvalid, bready, rready;
   logic [3:0]  wstrb;
   logic        awready, wready, arready, bvalid, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        reg_wr_en, reg_rd_en;
   logic [5:0]  reg_wr_addr, reg_rd_addr;
   logic [31:0] reg_wr_data;
   logic [3:0]  reg_wr_strb;
   logic [31:0] reg_rd_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   axi_lite_reg_slave dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .awaddr      (awaddr),
      .awprot      (awprot),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .wvalid      (wvalid),
      .wready      (wready),
      .bresp       (bresp),
      .bvalid      (bvalid),
      .bready      (bready),
      .araddr      (araddr),
      .arprot      (arprot),
      .arvalid     (arvalid),
      .arready     (arready),
      .rdata       (rdata),
      .rresp       (rresp),
      .rvalid      (rvalid),
      .rready      (rready),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .reg_wr_strb (reg_wr_strb),
      .reg_rd_en   (reg_rd_en),
      .reg_rd_addr (reg_rd_addr),
      .reg_rd_data (reg_rd_data)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   // Register bank model: byte-enabled writes, data one cycle after the read strobe.
   logic [31:0] regs [64] = '{default: 32'h0};
   always @(posedge aclk) begin
      if (reg_wr_en)
         for (int b = 0; b < 4; b++)
            if (reg_wr_strb[b]) regs[reg_wr_addr][8*b +: 8] <= reg_wr_data[8*b +: 8];
      if (reg_rd_en) reg_rd_data <= regs[reg_rd_addr];
   end

   // Monitor: counts and timestamps strobes and first cycle of each response.
   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, b_cnt = 0, r_cnt = 0;
   int          wr_cyc = 0, rd_cyc = 0, b_cyc = 0, r_cyc = 0;
   logic [5:0]  wr_addr_s = '0, rd_addr_s = '0;
   logic [31:0] wr_data_s = '0, r_data_s = '0;
   logic [3:0]  wr_strb_s = '0;
   logic [1:0]  b_resp_s = '0, r_resp_s = '0;
   logic        b_prev = 1'b0, r_prev = 1'b0;
   always @(negedge aclk) begin
      if (reg_wr_en) begin
         wr_cnt++; wr_cyc = cyc;
         wr_addr_s = reg_wr_addr; wr_data_s = reg_wr_data; wr_strb_s = reg_wr_strb;
      end
      if (reg_rd_en) begin
         rd_cnt++; rd_cyc = cyc; rd_addr_s = reg_rd_addr;
      end
      if (reg_wr_en && reg_rd_en) both_cnt++;
      if (bvalid && !b_prev) begin
         b_cnt++; b_cyc = cyc; b_resp_s = bresp;
      end
      if (rvalid && !r_prev) begin
         r_cnt++; r_cyc = cyc; r_resp_s = rresp; r_data_s = rdata;
      end
      b_prev = bvalid;
      r_prev = rvalid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Handshake edge numbers (value of cyc right after the accepting edge).
   int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;

   // Drive the selected valids together, called at posedge+1; drops each valid
   // after its handshake edge and returns at posedge+1 once all are accepted.
   task automatic xfer(input bit do_aw, input bit do_w, input bit do_ar,
                       input logic [31:0] a_w, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] a_r);
      logic aw_h, w_h, ar_h;
      awaddr = a_w; wdata = d; wstrb = s; araddr = a_r;
      awvalid = do_aw; wvalid = do_w; arvalid = do_ar;
      for (int i = 0; i < 20 && (awvalid || wvalid || arvalid); i++) begin
         @(negedge aclk);
         aw_h = awvalid && awready;
         w_h  = wvalid  && wready;
         ar_h = arvalid && arready;
         if (aw_h) aw_hs_cyc = cyc + 1;
         if (w_h)  w_hs_cyc  = cyc + 1;
         if (ar_h) ar_hs_cyc = cyc + 1;
         @(posedge aclk); #1;
         if (aw_h) awvalid = 1'b0;
         if (w_h)  wvalid  = 1'b0;
         if (ar_h) arvalid = 1'b0;
      end
      check("handshake_done", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
      awprot = 3'b000; arprot = 3'b000;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;

      // Reset state.
      settle(3);
      check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
      check("rst_valids",  {30'd0, bvalid, rvalid}, 32'd0);
      check("rst_strobes", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
      check("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
      check("rst_rdata",   rdata, 32'd0);
      @(negedge aclk); aresetn = 1'b1;
      #1 check("rdy_before_edge", {29'd0, awready, wready, arready}, 32'd0);
      @(posedge aclk); #1;
      check("rdy_after_edge", {29'd0, awready, wready, arready}, 32'd7);

      // Write 0x10, AW one cycle ahead of W.
      xfer(1, 0, 0, 32'h0000_0010, 32'h0, 4'h0, 32'h0);
      xfer(0, 1, 0, 32'h0, 32'hDEAD_BEEF, 4'hF, 32'h0);
      settle(6);
      check("w1_w_after_aw", w_hs_cyc, aw_hs_cyc + 1);
      check("w1_wr_cnt",     wr_cnt, 1);
      check("w1_addr",       wr_addr_s, 32'd4);
      check("w1_data",       wr_data_s, 32'hDEAD_BEEF);
      check("w1_strb",       wr_strb_s, 32'hF);
      check("w1_strobe_lat", wr_cyc, w_hs_cyc + 1);
      check("w1_b_lat",      b_cyc, wr_cyc + 1);
      check("w1_bresp",      b_resp_s, 32'd0);
      check("w1_b_cnt",      b_cnt, 1);

      // Read 0x10 back.
      xfer(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0010);
      settle(6);
      check("r1_rd_cnt",     rd_cnt, 1);
      check("r1_addr",       rd_addr_s, 32'd4);
      check("r1_strobe_lat", rd_cyc, ar_hs_cyc + 1);
      check("r1_r_lat",      r_cyc, ar_hs_cyc + 3);
      check("r1_rdata",      r_data_s, 32'hDEAD_BEEF);
      check("r1_rresp",      r_resp_s, 32'd0);

      // W before AW with partial strobes, then read back.
      xfer(0, 1, 0, 32'h0, 32'h1122_3344, 4'b0101, 32'h0);
      xfer(1, 0, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h0);
      settle(6);
      check("w2_wr_cnt", wr_cnt, 2);
      check("w2_addr",   wr_addr_s, 32'd8);
      check("w2_strb",   wr_strb_s, 32'h5);
      check("w2_lat",    wr_cyc, aw_hs_cyc + 1);
      check("w2_bresp",  b_resp_s, 32'd0);
      check("w2_b_cnt",  b_cnt, 2);
      xfer(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0020);
      settle(6);
      check("r2_addr",  rd_addr_s, 32'd8);
      check("r2_rdata", r_data_s, 32'h0022_0044);
      check("r2_rresp", r_resp_s, 32'd0);

      // Out-of-window write and read.
      xfer(1, 1, 0, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'h0);
      settle(6);
      check("miss_w_no_strobe", wr_cnt, 2);
      check("miss_b_cnt",       b_cnt, 3);
      check("miss_bresp",       b_resp_s, 32'd2);
      check("miss_b_lat",       b_cyc, aw_hs_cyc + 2);
      xfer(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0100);
      settle(6);
      check("miss_r_no_strobe", rd_cnt, 2);
      check("miss_r_cnt",       r_cnt, 3);
      check("miss_rresp",       r_resp_s, 32'd2);
      check("miss_rdata",       r_data_s, 32'd0);
      check("miss_r_lat",       r_cyc, ar_hs_cyc + 3);

      // Simultaneous AW/W/AR: write wins first, read wins the next contention.
      xfer(1, 1, 1, 32'h0000_0030, 32'hA5A5_0001, 4'hF, 32'h0000_0010);
      settle(8);
      check("arb1_wr_first", wr_cyc, aw_hs_cyc + 1);
      check("arb1_rd_next",  rd_cyc, ar_hs_cyc + 2);
      check("arb1_rdata",    r_data_s, 32'hDEAD_BEEF);
      check("arb1_counts",   {wr_cnt[15:0], rd_cnt[15:0]}, {16'd3, 16'd3});
      xfer(1, 1, 1, 32'h0000_0034, 32'h5A5A_0002, 4'hF, 32'h0000_0030);
      settle(8);
      check("arb2_rd_first", rd_cyc, ar_hs_cyc + 1);
      check("arb2_wr_next",  wr_cyc, aw_hs_cyc + 2);
      check("arb2_wr_addr",  wr_addr_s, 32'd13);
      check("arb2_rdata",    r_data_s, 32'hA5A5_0001);
      check("arb2_b_lat",    b_cyc, aw_hs_cyc + 3);
      check("no_overlap",    both_cnt, 0);

      // Write response stalled by bready, then reset mid-response.
      bready = 1'b0;
      xfer(1, 1, 0, 32'h0000_0014, 32'h0BAD_CAFE, 4'hF, 32'h0);
      settle(2);
      for (int i = 0; i < 5; i++) begin
         check("stall_bvalid",  bvalid, 32'd1);
         check("stall_bresp",   bresp, 32'd0);
         check("stall_awready", awready, 32'd0);
         settle(1);
      end
      check("stall_b_cnt",  b_cnt, 6);
      check("stall_wr_cnt", wr_cnt, 5);
      #1 aresetn = 1'b0;
      #1;
      check("arst_bvalid",  bvalid, 32'd0);
      check("arst_readies", {29'd0, awready, wready, arready}, 32'd0);
      check("arst_strobes", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
      check("arst_rvalid",  rvalid, 32'd0);
      check("arst_resp",    {28'd0, bresp, rresp}, 32'd0);
      check("arst_rdata",   rdata, 32'd0);
      @(negedge aclk); #1 aresetn = 1'b1;
      #1 check("arst_rdy_before_edge", {29'd0, awready, wready, arready}, 32'd0);
      settle(1);
      check("arst_rdy_after_edge", {29'd0, awready, wready, arready}, 32'd7);
      check("arst_bvalid_after",   bvalid, 32'd0);
      bready = 1'b1;
      settle(5);
      check("arst_discard_b",  b_cnt, 6);
      check("arst_discard_wr", wr_cnt, 5);
      xfer(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0014);
      settle(6);
      check("post_rst_rd_cnt", rd_cnt, 5);
      check("post_rst_rdata",  r_data_s, 32'h0BAD_CAFE);
      check("post_rst_rresp",  r_resp_s, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
